// File: rtl/video_timing_gen_if.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen_if
// Description : Raster timing bundle between the timing generator (master)
//               and the pixel renderer (slave). The renderer owns the pixel
//               enable; the generator drives syncs, data enable, positions,
//               strobes and frame parity.
// Revision    : 1.0 - initial release
// ============================================================================
interface video_timing_gen_if #(
    parameter int CNT_W = 10
);
    logic             en;
    logic             h_sync;
    logic             v_sync;
    logic             de;
    logic [CNT_W-1:0] x_pos;
    logic [CNT_W-1:0] y_pos;
    logic             line_start;
    logic             frame_start;
    logic             field;

    modport master (
        input  en,
        output h_sync, v_sync, de, x_pos, y_pos, line_start, frame_start, field
    );

    modport slave (
        output en,
        input  h_sync, v_sync, de, x_pos, y_pos, line_start, frame_start, field
    );
endinterface
`default_nettype wire

// File: rtl/video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : video_timing_gen
// Description : Parametrised raster timing generator. Line and frame order is
//               sync, back porch, active, front porch. All outputs are
//               registered from the next counter values, so they describe the
//               current (h, v) position with zero skew.
// Revision    : 1.0 - initial release
// ============================================================================
module video_timing_gen #(
    parameter int H_SYNC   = 41,
    parameter int H_BP     = 2,
    parameter int H_ACTIVE = 480,
    parameter int H_FP     = 2,
    parameter int V_SYNC   = 10,
    parameter int V_BP     = 2,
    parameter int V_ACTIVE = 272,
    parameter int V_FP     = 2,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 10
) (
    input  logic                clk_disp,
    input  logic                rst,
    video_timing_gen_if.master  vid
);

    localparam int c_H_TOTAL = H_SYNC + H_BP + H_ACTIVE + H_FP;
    localparam int c_V_TOTAL = V_SYNC + V_BP + V_ACTIVE + V_FP;
    localparam int c_H_START = H_SYNC + H_BP;
    localparam int c_V_START = V_SYNC + V_BP;

    // Inclusive bounds keep every constant representable in CNT_W bits even
    // when the front porch is zero and the total fills the counter range.
    localparam logic [CNT_W-1:0] c_H_LAST      = CNT_W'(c_H_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_V_LAST      = CNT_W'(c_V_TOTAL - 1);
    localparam logic [CNT_W-1:0] c_H_SYNC_W    = CNT_W'(H_SYNC);
    localparam logic [CNT_W-1:0] c_V_SYNC_W    = CNT_W'(V_SYNC);
    localparam logic [CNT_W-1:0] c_H_START_W   = CNT_W'(c_H_START);
    localparam logic [CNT_W-1:0] c_V_START_W   = CNT_W'(c_V_START);
    localparam logic [CNT_W-1:0] c_H_ACT_LAST  = CNT_W'(c_H_START + H_ACTIVE - 1);
    localparam logic [CNT_W-1:0] c_V_ACT_LAST  = CNT_W'(c_V_START + V_ACTIVE - 1);

    // Reject geometries the counters cannot hold or that lack sync/active.
    if ((c_H_TOTAL - 1 > (2 ** CNT_W) - 1) || (c_V_TOTAL - 1 > (2 ** CNT_W) - 1) ||
        (H_SYNC < 1) || (H_ACTIVE < 1) || (V_SYNC < 1) || (V_ACTIVE < 1) ||
        (H_BP < 0) || (H_FP < 0) || (V_BP < 0) || (V_FP < 0) ||
        (CNT_W < 1) || (CNT_W > 30)) begin : g_param_check
        $error("video_timing_gen: illegal geometry for CNT_W=%0d", CNT_W);
    end

    logic [CNT_W-1:0] r_h_cnt;
    logic [CNT_W-1:0] r_v_cnt;
    logic             r_h_sync;
    logic             r_v_sync;
    logic             r_de;
    logic [CNT_W-1:0] r_x_pos;
    logic [CNT_W-1:0] r_y_pos;
    logic             r_line_start;
    logic             r_frame_start;
    logic             r_field;

    logic [CNT_W-1:0] w_h_nxt;
    logic [CNT_W-1:0] w_v_nxt;
    logic             w_h_act;
    logic             w_v_act;
    logic             w_de;
    logic [CNT_W-1:0] w_x_pos;
    logic [CNT_W-1:0] w_y_pos;
    logic             w_origin;

    // Next raster position and the decode of every output from it.
    always_comb begin
        w_h_nxt = r_h_cnt + 1'b1;
        w_v_nxt = r_v_cnt;
        if (r_h_cnt == c_H_LAST) begin
            w_h_nxt = '0;
            w_v_nxt = (r_v_cnt == c_V_LAST) ? '0 : r_v_cnt + 1'b1;
        end
        w_h_act  = (w_h_nxt >= c_H_START_W) && (w_h_nxt <= c_H_ACT_LAST);
        w_v_act  = (w_v_nxt >= c_V_START_W) && (w_v_nxt <= c_V_ACT_LAST);
        w_de     = w_h_act && w_v_act;
        w_x_pos  = w_de ? (w_h_nxt - c_H_START_W) : '0;
        w_y_pos  = w_de ? (w_v_nxt - c_V_START_W) : '0;
        w_origin = (w_h_nxt == '0) && (w_v_nxt == '0);
    end

    // Counters and registered outputs advance together on enabled edges.
    // Reset parks the counters on the last pixel so the first enabled edge
    // lands exactly on (0,0) and starts a complete field-0 frame.
    always_ff @(posedge clk_disp or negedge rst) begin
        if (!rst) begin
            r_h_cnt       <= c_H_LAST;
            r_v_cnt       <= c_V_LAST;
            r_h_sync      <= ~HS_POL;
            r_v_sync      <= ~VS_POL;
            r_de          <= 1'b0;
            r_x_pos       <= '0;
            r_y_pos       <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
            r_field       <= 1'b1;
        end else if (vid.en) begin
            r_h_cnt       <= w_h_nxt;
            r_v_cnt       <= w_v_nxt;
            r_h_sync      <= (w_h_nxt < c_H_SYNC_W) ? HS_POL : ~HS_POL;
            r_v_sync      <= (w_v_nxt < c_V_SYNC_W) ? VS_POL : ~VS_POL;
            r_de          <= w_de;
            r_x_pos       <= w_x_pos;
            r_y_pos       <= w_y_pos;
            r_line_start  <= (w_h_nxt == '0);
            r_frame_start <= w_origin;
            r_field       <= r_field ^ w_origin;
        end
    end

    assign vid.h_sync      = r_h_sync;
    assign vid.v_sync      = r_v_sync;
    assign vid.de          = r_de;
    assign vid.x_pos       = r_x_pos;
    assign vid.y_pos       = r_y_pos;
    assign vid.line_start  = r_line_start;
    assign vid.frame_start = r_frame_start;
    assign vid.field       = r_field;

endmodule
`default_nettype wire
